// File: rtl/pixel_norm_sequencer_if.sv
// Handshake bundle between the pixel-normalizer sequencer and its environment:
// control, pixel-memory read port, normalizer port, status and credit count.
interface pixel_norm_sequencer_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CREDITS = 4
);
  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] frame_base;
  logic              credit_return;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              norm_valid_in;
  logic [7:0]        norm_pixel_in;
  logic              norm_valid_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CRED_W-1:0] credits;

  // Environment side: issues commands, returns memory data and normalizer results.
  modport master (
    output start, abort, frame_base, credit_return, mem_rdata, norm_valid_out,
    input  mem_rd_en, mem_addr, norm_valid_in, norm_pixel_in, busy, done, aborted, credits
  );

  // Sequencer side.
  modport slave (
    input  start, abort, frame_base, credit_return, mem_rdata, norm_valid_out,
    output mem_rd_en, mem_addr, norm_valid_in, norm_pixel_in, busy, done, aborted, credits
  );
endinterface

// File: rtl/pixel_norm_sequencer.sv
// Streams one IMG_W x IMG_H frame from pixel memory into a pixel normalizer,
// throttled by downstream credits, and waits for every normalized result.
module pixel_norm_sequencer #(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_norm_sequencer_if.slave  bus
);
  localparam int unsigned TOTAL  = IMG_W * IMG_H;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0]  TotalCnt  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  LastCnt   = CNT_W'(TOTAL - 1);
  localparam logic [CRED_W-1:0] MaxCred   = CRED_W'(CREDITS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    issue_cnt_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                norm_valid_q;
  logic                aborted_q;

  logic                active;
  logic                accept;
  logic                abort_hit;
  logic                issue;
  logic                last_issue;
  logic                out_inc;
  logic [CNT_W-1:0]    out_cnt_inc;
  logic                frame_out_done;

  assign active      = (state_q == StRun) || (state_q == StDrain);
  assign accept      = (state_q == StIdle) && bus.start;
  assign abort_hit   = active && bus.abort;
  assign issue       = (state_q == StRun) && (credits_q != '0) &&
                       (issue_cnt_q < TotalCnt) && !bus.abort;
  assign last_issue  = issue && (issue_cnt_q == LastCnt);
  assign out_inc     = active && bus.norm_valid_out;
  assign out_cnt_inc = out_cnt_q + CNT_W'(out_inc);
  // Completion counts the result arriving in this very cycle.
  assign frame_out_done = (out_cnt_inc == TotalCnt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over both forward transitions.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun: begin
        if (bus.abort)       state_d = StIdle;
        else if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (bus.abort)           state_d = StIdle;
        else if (frame_out_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Credits move in every state; a return when already full is dropped.
  always_comb begin
    credits_d = credits_q;
    if (issue && !bus.credit_return) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!issue && bus.credit_return && (credits_q < MaxCred)) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      issue_cnt_q  <= '0;
      out_cnt_q    <= '0;
      credits_q    <= MaxCred;
      norm_valid_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      if (accept) begin
        base_q      <= bus.frame_base;
        issue_cnt_q <= '0;
        out_cnt_q   <= '0;
      end else begin
        if (issue)   issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        if (out_inc) out_cnt_q   <= out_cnt_inc;
      end
      credits_q    <= credits_d;
      norm_valid_q <= issue;
      aborted_q    <= abort_hit;
    end
  end

  // Output logic
  always_comb begin
    bus.mem_rd_en     = issue;
    bus.mem_addr      = issue ? (base_q + ADDR_W'(issue_cnt_q)) : '0;
    bus.norm_valid_in = norm_valid_q;
    bus.norm_pixel_in = norm_valid_q ? bus.mem_rdata : 8'h00;
    bus.busy          = active;
    bus.done          = (state_q == StDone);
    bus.aborted       = aborted_q;
    bus.credits       = credits_q;
  end

endmodule

// File: doc/pixel_norm_sequencer.md
PIXEL_NORM_SEQUENCER -- requirements
Module: pixel_norm_sequencer

Interface
REQ-001 Parameter IMG_W, default 28, pixels per row.
REQ-002 Parameter IMG_H, default 28, rows per frame; TOTAL = IMG_W*IMG_H.
REQ-003 Parameter ADDR_W, default 16, pixel memory address width.
REQ-004 Parameter CREDITS, default 4, downstream buffer slots; CRED_W = clog2(CREDITS+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  frame request; honoured only in IDLE.
REQ-008 abort  in  1  terminate current frame; honoured only in RUN/DRAIN.
REQ-009 frame_base  in  ADDR_W  frame start address, latched on accepted start.
REQ-010 credit_return  in  1  one downstream slot freed this cycle.
REQ-011 mem_rd_en  out  1  pixel memory read strobe.
REQ-012 mem_addr  out  ADDR_W  pixel memory read address.
REQ-013 mem_rdata  in  8  read data, valid exactly one cycle after mem_rd_en.
REQ-014 norm_valid_in  out  1  valid to pixel normalizer.
REQ-015 norm_pixel_in  out  8  pixel to pixel normalizer.
REQ-016 norm_valid_out  in  1  normalizer result valid (one-cycle normalizer latency).
REQ-017 busy  out  1  high in RUN and DRAIN.
REQ-018 done  out  1  one-cycle frame-complete pulse.
REQ-019 aborted  out  1  one-cycle abort-acknowledge pulse.
REQ-020 credits  out  CRED_W  current credit count.

Function
REQ-021 States SHALL be IDLE, RUN, DRAIN, DONE; encoding free.
REQ-022 IDLE: start=1 at an edge latches frame_base, clears issue_cnt and out_cnt, enters RUN.
REQ-023 RUN: mem_rd_en SHALL be combinational = (credits>0) & (issue_cnt<TOTAL) & !abort.
REQ-024 mem_addr SHALL equal (base_q + issue_cnt) mod 2^ADDR_W; row-major, no gaps; 0 when mem_rd_en=0.
REQ-025 Each cycle with mem_rd_en=1 SHALL increment issue_cnt by 1.
REQ-026 Credits: next = credits - issue + credit_return; simultaneous issue and return leaves credits unchanged.
REQ-027 credit_return at credits==CREDITS with no issue SHALL be ignored (saturate, no wrap).
REQ-028 Credits SHALL update in every state, including IDLE, and are never reset by abort.
REQ-029 Issuing the TOTAL-th pixel SHALL move RUN to DRAIN at that edge.
REQ-030 norm_valid_in SHALL be mem_rd_en registered one cycle; norm_pixel_in = mem_rdata when norm_valid_in=1, else 0.
REQ-031 out_cnt SHALL increment on norm_valid_out=1 in RUN or DRAIN only; ignored in IDLE/DONE.
REQ-032 DRAIN SHALL move to DONE at the edge where out_cnt reaches TOTAL (including that cycle's norm_valid_out).
REQ-033 DONE SHALL last exactly one cycle with done=1, busy=0, then IDLE.
REQ-034 abort=1 in RUN/DRAIN: no issue that cycle, next state IDLE, aborted=1 for the following cycle only, no done.
REQ-035 abort SHALL take priority over RUN->DRAIN and DRAIN->DONE in the same cycle.
REQ-036 start outside IDLE and abort in IDLE/DONE SHALL be ignored.
REQ-037 Frame end-to-end latency: first mem_rd_en in the cycle after start accepted if credits>0; first norm_valid_out two cycles after it.

Reset
REQ-038 rst=1 SHALL immediately force IDLE, issue_cnt=out_cnt=0, base_q=0, credits=CREDITS.
REQ-039 During and after reset: mem_rd_en=0, mem_addr=0, norm_valid_in=0, norm_pixel_in=0, busy=0, done=0, aborted=0.
REQ-040 Reset mid-frame SHALL discard the frame with no done or aborted pulse.

Verification
REQ-041 Default params, base 0x0100, credit_return held 1 from 2 cycles after each issue -> addresses 0x0100..0x040F consecutive, 784 norm_valid_in, single done pulse after 784th norm_valid_out.
REQ-042 credit_return held 0 -> exactly 4 reads, mem_rd_en stays 0, busy=1; one credit_return pulse -> exactly one further read.
REQ-043 credits=1, issue and credit_return same cycle -> credits stays 1; return at credits=4 with no issue -> stays 4.
REQ-044 abort after 100 issues -> mem_rd_en=0 in abort cycle, aborted=1 next cycle only, state IDLE, done never asserted, credits not reloaded.
REQ-045 IMG_W=8, IMG_H=4, base 0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x000F.
REQ-046 start pulsed during RUN ignored; rst asserted in DRAIN -> all outputs 0 same cycle, credits=4, next start runs a full frame.
